// File: rtl/asyn_fifo_pkg.sv
// Shared defaults for asyn_fifo: word width, depth and pointer-width derivation.
package asyn_fifo_pkg;

  localparam int unsigned FIFO_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 16;

  // Memory index width; pointers carry one extra wrap bit on top of this.
  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/asyn_fifo_mem.sv
// DEPTH x WIDTH register array with synchronous write and a registered read port.
// Latency: rd_data updates 1 cycle after the edge with rd_en; holds otherwise.
// Backpressure: none; the caller only issues accepted reads and writes.
module asyn_fifo_mem
  import asyn_fifo_pkg::*;
#(
  parameter int unsigned WIDTH  = FIFO_WIDTH,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = fifo_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  // Storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/asyn_fifo.sv
// Single-clock FIFO with full/empty flags and error flags; FIFO_STICKY_ERR_EN makes errors latch until rst.
// Latency: read_data 1 cycle after an accepted read; no fall-through when empty.
// Backpressure: writes dropped when full (write_error), reads ignored when empty (read_error).
module asyn_fifo
  import asyn_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic             read_en,
  input  logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] read_data,
  output logic             full,
  output logic             empty,
  output logic             read_error,
  output logic             write_error
);

  localparam int unsigned ADDR_W = fifo_addr_w(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic            rd_err_q, rd_err_d;
  logic            wr_err_q, wr_err_d;
  logic            wr_acc;
  logic            rd_acc;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign wr_acc = write_en & ~full;
  assign rd_acc = read_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_comb begin
`ifdef FIFO_STICKY_ERR_EN
    rd_err_d = rd_err_q | (read_en & empty);
    wr_err_d = wr_err_q | (write_en & full);
`else
    rd_err_d = read_en & empty;
    wr_err_d = write_en & full;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rd_err_q <= rd_err_d;
      wr_err_q <= wr_err_d;
    end
  end

  asyn_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[ADDR_W-1:0]),
    .wr_data (write_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q[ADDR_W-1:0]),
    .rd_data (read_data)
  );

  assign read_error  = rd_err_q;
  assign write_error = wr_err_q;

endmodule

// File: tb/tb_asyn_fifo.sv
// Bench for asyn_fifo: queue-based model checked every cycle plus directed literal checks.
module tb_asyn_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             write_en = 1'b0;
  logic             read_en = 1'b0;
  logic [WIDTH-1:0] write_data = '0;
  logic [WIDTH-1:0] read_data;
  logic             full, empty, read_error, write_error;

  int n_chk  = 0;
  int n_pass = 0;

  asyn_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .write_en    (write_en),
    .read_en     (read_en),
    .write_data  (write_data),
    .read_data   (read_data),
    .full        (full),
    .empty       (empty),
    .read_error  (read_error),
    .write_error (write_error)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of stored words plus the expected registered outputs.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_rd = '0;
  logic             m_rerr = 1'b0;
  logic             m_werr = 1'b0;
  bit               m_ok = 1'b0;

  always @(posedge clk) begin
    bit was_full, was_empty;
    if (rst) begin
      mq.delete();
      m_rd = '0;
      m_rerr = 1'b0;
      m_werr = 1'b0;
      m_ok = 1'b1;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
`ifdef FIFO_STICKY_ERR_EN
      m_werr = m_werr | (write_en & was_full);
      m_rerr = m_rerr | (read_en & was_empty);
`else
      m_werr = write_en & was_full;
      m_rerr = read_en & was_empty;
`endif
      if (read_en && !was_empty) m_rd = mq.pop_front();
      if (write_en && !was_full) mq.push_back(write_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  int werr_seen = 0;
  int rerr_seen = 0;

  always @(negedge clk) begin
    if (m_ok) begin
      check("model_empty",     32'(empty),       32'(mq.size() == 0));
      check("model_full",      32'(full),        32'(mq.size() == DEPTH));
      check("model_read_data", 32'(read_data),   32'(m_rd));
      check("model_read_err",  32'(read_error),  32'(m_rerr));
      check("model_write_err", 32'(write_error), 32'(m_werr));
    end
    if (write_error === 1'b1) werr_seen++;
    if (read_error === 1'b1) rerr_seen++;
  end

  // Inputs change on the falling edge; returns at the next falling edge.
  task automatic step(input logic we, input logic re, input logic [WIDTH-1:0] wd);
    write_en = we;
    read_en = re;
    write_data = wd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] tbl [16] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0d, 8'h8d, 8'h65, 8'h12,
                                 8'h01, 8'h0d, 8'h76, 8'h3d, 8'hed, 8'h8c, 8'hf9, 8'hc6};

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_read_data", 32'(read_data), 32'd0);
    check("reset_errors", 32'({read_error, write_error}), 32'd0);

    // 1: fill with 16 words
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, tbl[i]);
    check("t1_full", 32'(full), 32'd1);
    check("t1_empty", 32'(empty), 32'd0);
    check("t1_write_error", 32'(write_error), 32'd0);

    // 2: drain in write order
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, '0);
      check("t2_read_data", 32'(read_data), 32'(tbl[i]));
    end
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_read_error", 32'(read_error), 32'd0);
    step(1'b0, 1'b0, '0);
    check("t2_hold", 32'(read_data), 32'h0000_00c6);

    // 3: reads on an empty FIFO after reset
    do_reset();
    rerr_seen = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, '0);
      check("t3_read_error", 32'(read_error), 32'd1);
      check("t3_read_data", 32'(read_data), 32'd0);
      check("t3_empty", 32'(empty), 32'd1);
    end
    step(1'b0, 1'b0, '0);
    check("t3_err_clears", 32'(read_error), 32'd0);
    check("t3_err_count", 32'(rerr_seen), 32'd16);

    // 4: 21 writes, 5 overflow, drain returns first 16
    do_reset();
    werr_seen = 0;
    for (int i = 0; i < 21; i++) step(1'b1, 1'b0, 8'(8'ha0 + i));
    step(1'b0, 1'b0, '0);
    check("t4_full", 32'(full), 32'd1);
    check("t4_werr_count", 32'(werr_seen), 32'd5);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, '0);
      check("t4_drain", 32'(read_data), 32'(8'ha0 + i));
    end
    check("t4_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, '0);
    check("t4_underflow", 32'(read_error), 32'd1);
    check("t4_underflow_hold", 32'(read_data), 32'h0000_00af);

    // 5: simultaneous read/write from empty
    do_reset();
    rerr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'h40 + i));
      if (i == 0) begin
        check("t5_first_rerr", 32'(read_error), 32'd1);
        check("t5_first_rd", 32'(read_data), 32'd0);
      end else begin
        check("t5_stream", 32'(read_data), 32'(8'h40 + i - 1));
        check("t5_read_error", 32'(read_error), 32'd0);
      end
      check("t5_occupancy", 32'({full, empty}), 32'd0);
    end
    check("t5_rerr_count", 32'(rerr_seen), 32'd1);

    // 6: pointer wrap, then reset mid-stream
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, '0);
      check("t6_rd_a", 32'(read_data), 32'(8'h10 + i));
    end
    check("t6_empty_a", 32'(empty), 32'd1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    check("t6_not_full", 32'(full), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, '0);
      check("t6_rd_b", 32'(read_data), 32'(8'h60 + i));
    end
    check("t6_empty_b", 32'(empty), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hc0 + i));
    check("t6_pre_rst_empty", 32'(empty), 32'd0);
    rst = 1'b1;
    step(1'b1, 1'b1, 8'hee);
    rst = 1'b0;
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_read_data", 32'(read_data), 32'd0);
    step(1'b0, 1'b0, '0);
    check("t6_post_rst_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
